// File: rtl/game_scoreboard.sv
// game_scoreboard: turns GAME core level outputs (winner/loser/gameover) into
// single-cycle events. It keeps saturating win/loss tallies and the match
// result, and queues every accepted event in a small FIFO that a host drains
// over a valid/ready handshake.
// Optional feature: define SCOREBOARD_STREAK_EN to track the longest run of
// consecutive wins on best_streak. Without it, best_streak is tied to 0.
module game_scoreboard #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winner,
  input  logic             loser,
  input  logic             gameover,
  input  logic [1:0]       who,
  input  logic             clr,
  output logic [CNT_W-1:0] win_count,
  output logic [CNT_W-1:0] loss_count,
  output logic             match_done,
  output logic [1:0]       match_who,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_data,
  output logic             overflow,
  output logic             conflict,
  output logic [CNT_W-1:0] best_streak
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t state_q, state_d;

  logic winner_q, loser_q, gameover_q;
  logic ev_win, ev_loss, ev_go;
  logic active, take_win, take_loss, take_go, has_wl, conflict_set;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, fits;
  logic [CW:0]   free_slots;
  logic [1:0]    n_push, n_acc;
  logic [3:0]    e0, e1, wl_entry, go_entry;

  assign ev_win  = winner & ~winner_q;
  assign ev_loss = loser & ~loser_q;
  assign ev_go   = gameover & ~gameover_q;

  assign evt_valid  = (count != '0);
  assign evt_data   = mem[rd_ptr];
  assign match_done = (state_q == DONE);
  assign pop        = evt_valid & evt_ready;

  // Edge history always tracks the inputs, even during clr, so a held level never re-fires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      winner_q   <= winner;
      loser_q    <= loser;
      gameover_q <= gameover;
    end
  end

  // Event qualification and push planning: win/loss goes first, gameover second
  always_comb begin
    active       = ~clr & (state_q != DONE);
    take_win     = active & ev_win;
    take_loss    = active & ev_loss & ~ev_win;
    take_go      = active & ev_go;
    conflict_set = active & ev_win & ev_loss;
    has_wl       = take_win | take_loss;
    wl_entry     = {(take_win ? 2'b01 : 2'b10), who};
    go_entry     = {2'b11, who};
    e0           = has_wl ? wl_entry : go_entry;
    e1           = go_entry;
    n_push       = {1'b0, has_wl} + {1'b0, take_go};
    free_slots   = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(pop);
    fits         = ((CW+1)'(n_push) <= free_slots);
    n_acc        = fits ? n_push : free_slots[1:0];
  end

  // Match FSM next-state: clr always returns to IDLE, DONE holds until then
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (take_go) state_d = DONE; else if (has_wl) state_d = PLAYING;
        PLAYING: if (take_go) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Match FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Tallies, match result and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_count  <= '0;
      loss_count <= '0;
      match_who  <= 2'b00;
      overflow   <= 1'b0;
      conflict   <= 1'b0;
    end else if (clr) begin
      win_count  <= '0;
      loss_count <= '0;
      match_who  <= 2'b00;
      overflow   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      if (take_win && win_count != CNT_MAX)   win_count  <= win_count + CNT_W'(1);
      if (take_loss && loss_count != CNT_MAX) loss_count <= loss_count + CNT_W'(1);
      if (take_go)      match_who <= who;
      if (!fits)        overflow  <= 1'b1;
      if (conflict_set) conflict  <= 1'b1;
    end
  end

  // Event FIFO: up to two pushes plus one pop per cycle, excess pushes are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'h0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (n_acc != 2'd0) mem[wr_ptr] <= e0;
      if (n_acc == 2'd2) mem[wr_ptr + PW'(1)] <= e1;
      wr_ptr <= wr_ptr + PW'(n_acc);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_acc) - CW'(pop);
    end
  end

`ifdef SCOREBOARD_STREAK_EN
  logic [CNT_W-1:0] cur_streak, streak_inc;

  assign streak_inc = (cur_streak == CNT_MAX) ? cur_streak : cur_streak + CNT_W'(1);

  // Current win run and the best run seen since the last clr/reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_streak  <= '0;
      best_streak <= '0;
    end else if (clr) begin
      cur_streak  <= '0;
      best_streak <= '0;
    end else if (take_win) begin
      cur_streak <= streak_inc;
      if (streak_inc > best_streak) best_streak <= streak_inc;
    end else if (take_loss) begin
      cur_streak <= '0;
    end
  end
`else
  assign best_streak = '0;
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
// Directed testbench for game_scoreboard (CNT_W=8, FIFO_DEPTH=4).
module tb_game_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       winner = 1'b0, loser = 1'b0, gameover = 1'b0, clr = 1'b0, evt_ready = 1'b0;
  logic [1:0] who = 2'b00;
  logic [7:0] win_count, loss_count, best_streak;
  logic       match_done, evt_valid, overflow, conflict;
  logic [1:0] match_who;
  logic [3:0] evt_data;

  int tests_run = 0;
  int tests_failed = 0;

  game_scoreboard #(.CNT_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .winner(winner), .loser(loser), .gameover(gameover),
    .who(who), .clr(clr), .win_count(win_count), .loss_count(loss_count),
    .match_done(match_done), .match_who(match_who), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .overflow(overflow),
    .conflict(conflict), .best_streak(best_streak)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic win_pulse(input logic [1:0] w);
    who = w;
    winner = 1'b1;
    tick();
    winner = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests_run++;
    if ({win_count, loss_count, match_done, match_who, evt_valid, overflow, conflict, best_streak} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got win=%0d loss=%0d done=%b who=%0d valid=%b ovf=%b conf=%b best=%0d required all 0",
               win_count, loss_count, match_done, match_who, evt_valid, overflow, conflict, best_streak);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_win();
    who = 2'd1;
    winner = 1'b1;
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_no_bypass: got valid=%b required 0", evt_valid);
    end
    tick();
    tests_run++;
    if (win_count !== 8'd1 || evt_valid !== 1'b1 || evt_data !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL single_win: got win=%0d valid=%b data=%b required 1 1 0101", win_count, evt_valid, evt_data);
    end
    tick(); tick();
    winner = 1'b0;
    tests_run++;
    if (win_count !== 8'd1) begin
      tests_failed++; $display("[TB] FAIL single_win_hold: got win=%0d required 1", win_count);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_pop: got valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_held_level();
    who = 2'd1;
    evt_ready = 1'b1;
    winner = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    winner = 1'b0;
    evt_ready = 1'b0;
    tests_run++;
    if (win_count !== 8'd2 || evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL held_win: got win=%0d valid=%b required 2 0", win_count, evt_valid);
    end
    tick();
    who = 2'd2;
    loser = 1'b1;
    tick();
    tests_run++;
    if (loss_count !== 8'd1 || evt_data !== 4'b1010 || evt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL held_loss: got loss=%0d data=%b valid=%b required 1 1010 1", loss_count, evt_data, evt_valid);
    end
    loser = 1'b0;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [1:0] w;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      w = 2'(i);
      win_pulse(w);
      if (i == 3) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL ovf_at_full: got ovf=%b required 0", overflow);
        end
      end
    end
    tests_run++;
    if (win_count !== 8'd5 || overflow !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ovf_set: got win=%0d ovf=%b required 5 1", win_count, overflow);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 2'(i);
      tests_run++;
      if (evt_valid !== 1'b1 || evt_data !== {2'b01, w}) begin
        tests_failed++;
        $display("[TB] FAIL ovf_drain_%0d: got valid=%b data=%b required 1 %b", i, evt_valid, evt_data, {2'b01, w});
      end
      tick();
    end
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ovf_empty: got valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q [4];
    do_clr();
    tests_run++;
    if (overflow !== 1'b0 || win_count !== 8'd0) begin
      tests_failed++; $display("[TB] FAIL b2b_clr: got ovf=%b win=%0d required 0 0", overflow, win_count);
    end
    for (int i = 0; i < 4; i++) win_pulse(2'(i));
    who = 2'd2;
    winner = 1'b1;
    evt_ready = 1'b1;
    tick();
    winner = 1'b0;
    evt_ready = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || win_count !== 8'd5 || evt_data !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL b2b_full_pushpop: got ovf=%b win=%0d head=%b required 0 5 0101", overflow, win_count, evt_data);
    end
    exp_q[0] = 4'b0101; exp_q[1] = 4'b0110; exp_q[2] = 4'b0111; exp_q[3] = 4'b0110;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_drain_%0d: got valid=%b data=%b required 1 %b", i, evt_valid, evt_data, exp_q[i]);
      end
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_conflict();
    do_clr();
    who = 2'd1;
    winner = 1'b1;
    loser = 1'b1;
    tick();
    winner = 1'b0;
    loser = 1'b0;
    tests_run++;
    if (win_count !== 8'd1 || loss_count !== 8'd0 || conflict !== 1'b1 || evt_data !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL conflict: got win=%0d loss=%0d conf=%b data=%b required 1 0 1 0101",
               win_count, loss_count, conflict, evt_data);
    end
    tick();
    do_clr();
    tests_run++;
    if (conflict !== 1'b0 || evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL conflict_clr: got conf=%b valid=%b required 0 0", conflict, evt_valid);
    end
  endtask

  task automatic test_gameover_combo();
    do_clr();
    who = 2'd2;
    winner = 1'b1;
    gameover = 1'b1;
    tick();
    winner = 1'b0;
    gameover = 1'b0;
    tests_run++;
    if (win_count !== 8'd1 || match_done !== 1'b1 || match_who !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL combo_state: got win=%0d done=%b who=%0d required 1 1 2", win_count, match_done, match_who);
    end
    evt_ready = 1'b1;
    tests_run++;
    if (evt_data !== 4'b0110) begin
      tests_failed++; $display("[TB] FAIL combo_first: got data=%b required 0110", evt_data);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== 4'b1110) begin
      tests_failed++; $display("[TB] FAIL combo_second: got valid=%b data=%b required 1 1110", evt_valid, evt_data);
    end
    tick();
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL combo_empty: got valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_gameover();
    do_clr();
    who = 2'd3;
    gameover = 1'b1;
    tick();
    gameover = 1'b0;
    tests_run++;
    if (match_done !== 1'b1 || match_who !== 2'd3 || evt_data !== 4'b1111 || evt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL gameover: got done=%b who=%0d data=%b valid=%b required 1 3 1111 1",
               match_done, match_who, evt_data, evt_valid);
    end
    tick();
    win_pulse(2'd1);
    tests_run++;
    if (win_count !== 8'd0) begin
      tests_failed++; $display("[TB] FAIL done_ignores_win: got win=%0d required 0", win_count);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL done_no_push: got valid=%b required 0", evt_valid);
    end
    winner = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick();
    winner = 1'b0;
    tests_run++;
    if (win_count !== 8'd0 || match_done !== 1'b0 || match_who !== 2'd0 || evt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_priority: got win=%0d done=%b who=%0d valid=%b required 0 0 0 0",
               win_count, match_done, match_who, evt_valid);
    end
    tick();
  endtask

  task automatic test_streak();
    logic [7:0] exp_best;
    do_clr();
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) win_pulse(2'd0);
    loser = 1'b1; tick(); loser = 1'b0; tick();
    for (int i = 0; i < 2; i++) win_pulse(2'd0);
    evt_ready = 1'b0;
`ifdef SCOREBOARD_STREAK_EN
    exp_best = 8'd3;
`else
    exp_best = 8'd0;
`endif
    tests_run++;
    if (best_streak !== exp_best || win_count !== 8'd5 || loss_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL streak: got best=%0d win=%0d loss=%0d required %0d 5 1", best_streak, win_count, loss_count, exp_best);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    evt_ready = 1'b1;
    for (int i = 0; i < 255; i++) win_pulse(2'd1);
    tests_run++;
    if (win_count !== 8'd255) begin
      tests_failed++; $display("[TB] FAIL sat_reach: got win=%0d required 255", win_count);
    end
    who = 2'd3;
    winner = 1'b1;
    tick();
    winner = 1'b0;
    tests_run++;
    if (win_count !== 8'd255 || evt_valid !== 1'b1 || evt_data !== 4'b0111) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold_push: got win=%0d valid=%b data=%b required 255 1 0111", win_count, evt_valid, evt_data);
    end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clr();
    for (int i = 0; i < 3; i++) win_pulse(2'(i));
    evt_ready = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({win_count, loss_count, match_done, match_who, evt_valid, overflow, conflict, best_streak} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got win=%0d valid=%b best=%0d required 0 0 0", win_count, evt_valid, best_streak);
    end
    evt_ready = 1'b0;
    #3;
    rst = 1'b1;
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || win_count !== 8'd0) begin
      tests_failed++; $display("[TB] FAIL reset_release: got valid=%b win=%0d required 0 0", evt_valid, win_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_win();
    test_held_level();
    test_overflow();
    test_back_to_back();
    test_conflict();
    test_gameover_combo();
    test_gameover();
    test_streak();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
